// File: rtl/sample_fifo.sv
// sample_fifo: FWFT circular buffer behind the SIPO ADC capture path.
// Optional THRESHOLD_TRIG_EN adds trig_level/trig threshold pulse.
module sample_fifo #(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              data_ready,
  input  logic              rd_ready,
  input  logic              clear_ovf,
`ifdef THRESHOLD_TRIG_EN
  input  logic [DATA_W-1:0] trig_level,
  output logic              trig,
`endif
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              overflow
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              dr_q;
  logic              wr_stb;
  logic              wr_en;
  logic              rd_fire;
  logic              drop;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign rd_valid = ~empty;
  assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

  assign wr_stb  = data_ready & ~dr_q;
  assign rd_fire = rd_valid & rd_ready;
  assign wr_en   = wr_stb & (~full | rd_fire);
  assign drop    = wr_stb & full & ~rd_fire;

  // dr_q tracks data_ready even in reset so a held strobe never re-fires
  always_ff @(posedge clk) begin
    dr_q <= data_ready;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= sample_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en)   wr_ptr <= wr_ptr + 1'b1;
      if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // a drop in the same cycle as clear_ovf keeps the flag set
  always_ff @(posedge clk) begin
    if (reset)          overflow <= 1'b0;
    else if (drop)      overflow <= 1'b1;
    else if (clear_ovf) overflow <= 1'b0;
  end

`ifdef THRESHOLD_TRIG_EN
  always_ff @(posedge clk) begin
    if (reset) trig <= 1'b0;
    else       trig <= wr_en & (sample_in >= trig_level);
  end
`endif

endmodule

// File: tb/tb_sample_fifo.sv
// tb_sample_fifo: directed scoreboard bench for sample_fifo.
// Monitor pops expected words whenever the read port fires.
module tb_sample_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] sample_in;
  logic        data_ready;
  logic        rd_ready;
  logic        clear_ovf;
  logic        rd_valid;
  logic [11:0] rd_data;
  logic [4:0]  count;
  logic        full;
  logic        empty;
  logic        overflow;
`ifdef THRESHOLD_TRIG_EN
  logic [11:0] trig_level;
  logic        trig;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  logic [11:0] q[$];
  int          mcount;
  logic        movf;
  logic        mdr;

  sample_fifo dut (
    .clk        (clk),
    .reset      (reset),
    .sample_in  (sample_in),
    .data_ready (data_ready),
    .rd_ready   (rd_ready),
    .clear_ovf  (clear_ovf),
`ifdef THRESHOLD_TRIG_EN
    .trig_level (trig_level),
    .trig       (trig),
`endif
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && rd_valid && rd_ready) begin
      if (q.size() == 0) begin
        chk("rd_unexpected", int'(rd_data), -1);
      end else begin
        chk("rd_data", int'(rd_data), int'(q.pop_front()));
      end
    end
  end

  // drive one cycle of inputs and advance the reference model
  task automatic step(input logic dr, input logic [11:0] s,
                      input logic rr, input logic co,
                      input logic rs);
    logic stb, rdf, fl;
    reset      = rs;
    data_ready = dr;
    sample_in  = s;
    rd_ready   = rr;
    clear_ovf  = co;
    if (rs) begin
      q.delete();
      mcount = 0;
      movf   = 1'b0;
    end else begin
      stb = dr & ~mdr;
      rdf = rr & (mcount != 0);
      fl  = (mcount == 16);
      if (stb && (!fl || rdf)) begin
        q.push_back(s);
        if (!rdf) mcount++;
      end else if (rdf) begin
        mcount--;
      end
      if (stb && fl && !rdf) movf = 1'b1;
      else if (co)           movf = 1'b0;
    end
    mdr = dr;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [11:0] v);
    step(1'b1, v, 1'b0, 1'b0, 1'b0);
    step(1'b1, v, 1'b0, 1'b0, 1'b0);
    step(1'b0, v, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    int guard = 0;
    while (mcount != 0 && guard < 100) begin
      step(1'b0, 12'h0, 1'b1, 1'b0, 1'b0);
      guard++;
    end
    step(1'b0, 12'h0, 1'b0, 1'b0, 1'b0);
    chk("drain_done", mcount, 0);
    chk("drain_empty", int'(empty), 1);
    chk("drain_queue", q.size(), 0);
  endtask

  task automatic do_reset();
    step(1'b0, 12'h0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 12'h0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 12'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; data_ready = 1'b0; sample_in = '0;
    rd_ready = 1'b0; clear_ovf = 1'b0;
    mcount = 0; movf = 1'b0; mdr = 1'b0;
`ifdef THRESHOLD_TRIG_EN
    trig_level = 12'h800;
`endif
    do_reset();
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_valid", int'(rd_valid), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_data", int'(rd_data), 0);

    // single 2-cycle strobe -> one write
    step(1'b1, 12'h0A5, 1'b0, 1'b0, 1'b0);
    step(1'b1, 12'h0A5, 1'b0, 1'b0, 1'b0);
    chk("one_count", int'(count), 1);
    chk("one_valid", int'(rd_valid), 1);
    chk("one_data", int'(rd_data), 12'h0A5);
    step(1'b0, 12'h0, 1'b1, 1'b0, 1'b0);
    chk("one_empty", int'(empty), 1);
    chk("one_count0", int'(count), 0);

    // fill, overflow, drain in order
    for (int i = 0; i < 16; i++) wr(12'(i));
    chk("fill_full", int'(full), 1);
    chk("fill_count", int'(count), 16);
    wr(12'h0FF);
    chk("drop_ovf", int'(overflow), 1);
    chk("drop_count", int'(count), 16);
    drain();
    step(1'b0, 12'h0, 1'b0, 1'b1, 1'b0);
    chk("clr_ovf", int'(overflow), 0);

    // write and read together while full
    for (int i = 0; i < 16; i++) wr(12'h200 + 12'(i));
    step(1'b1, 12'h123, 1'b1, 1'b0, 1'b0);
    chk("wrrd_count", int'(count), 16);
    chk("wrrd_ovf", int'(overflow), 0);
    step(1'b1, 12'h123, 1'b0, 1'b0, 1'b0);
    step(1'b0, 12'h123, 1'b0, 1'b0, 1'b0);
    drain();

    // interleaved traffic across pointer wrap
    for (int i = 0; i < 40; i++) begin
      for (int k = 0; k < 3; k++) begin
        step(k < 2, 12'h300 + 12'(i), 1'($urandom_range(0, 1)),
             1'b0, 1'b0);
        chk("mix_count", int'(count), mcount);
      end
    end
    drain();

    // reset in the second cycle of a strobe with words stored
    wr(12'h400); wr(12'h401); wr(12'h402);
    step(1'b1, 12'h4AA, 1'b0, 1'b0, 1'b0);
    step(1'b1, 12'h4AA, 1'b0, 1'b0, 1'b1);
    chk("mid_empty", int'(empty), 1);
    chk("mid_ovf", int'(overflow), 0);
    step(1'b1, 12'h4AA, 1'b0, 1'b0, 1'b0);
    step(1'b0, 12'h4AA, 1'b0, 1'b0, 1'b0);
    chk("mid_nowrite", int'(count), 0);
    wr(12'h555);
    chk("mid_rewrite", int'(count), 1);
    chk("mid_data", int'(rd_data), 12'h555);
    for (int i = 0; i < 15; i++) wr(12'h600 + 12'(i));
    chk("mid_full", int'(full), 1);
    step(1'b1, 12'h666, 1'b0, 1'b1, 1'b0);
    chk("clr_vs_drop", int'(overflow), 1);
    step(1'b0, 12'h666, 1'b0, 1'b0, 1'b0);
    chk("ovf_model", int'(overflow), int'(movf));
    drain();

`ifdef THRESHOLD_TRIG_EN
    do_reset();
    chk("trig_rst", int'(trig), 0);
    step(1'b1, 12'h7FF, 1'b0, 1'b0, 1'b0);
    chk("trig_7ff", int'(trig), 0);
    step(1'b1, 12'h7FF, 1'b0, 1'b0, 1'b0);
    step(1'b0, 12'h7FF, 1'b0, 1'b0, 1'b0);
    step(1'b1, 12'h800, 1'b0, 1'b0, 1'b0);
    chk("trig_800", int'(trig), 1);
    step(1'b1, 12'h800, 1'b0, 1'b0, 1'b0);
    chk("trig_pulse", int'(trig), 0);
    step(1'b0, 12'h800, 1'b0, 1'b0, 1'b0);
    step(1'b1, 12'hFFF, 1'b0, 1'b0, 1'b0);
    chk("trig_fff", int'(trig), 1);
    step(1'b1, 12'hFFF, 1'b0, 1'b0, 1'b0);
    step(1'b0, 12'hFFF, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 13; i++) wr(12'h000);
    chk("trig_full", int'(full), 1);
    step(1'b1, 12'hFFF, 1'b0, 1'b0, 1'b0);
    chk("trig_drop", int'(trig), 0);
    chk("trig_ovf", int'(overflow), 1);
    step(1'b0, 12'hFFF, 1'b0, 1'b0, 1'b0);
    drain();
`endif

    chk("final_queue", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
